// File: rtl/m8x8_drain.sv
// -----------------------------------------------------------------------------
// m8x8_drain -- capture side of an 8x8 systolic array output drain.
//
// Each array row emits a clear pulse followed by eight serial elements (plus
// one relu-derivative bit per element). Every row has its own capture FSM, so
// rows may be skewed in time. Completed tiles land in one of two banks; a full
// bank is then drained to the downstream side one tile row per beat with a
// valid/ready handshake.
//
// Ports
//   clk       single clock, rising edge
//   reset     asynchronous active-high reset
//   enable    capture-side advance (array global enable)
//   clear_in  per-row clear pulses, bit r = row r
//   z_in      per-row element stream, row r at [r*DW +: DW]
//   b_in      per-row derivative bit accompanying z_in
//   m_ready   downstream accepts the current beat
//   m_valid   a tile row is presented
//   m_data    tile row, column c at [c*DW +: DW]
//   m_bmask   derivative bits of the row, bit c = column c
//   m_row     row index of the beat
//   m_last    high on row 7
//   ovf       sticky: a tile row was dropped (target bank full)
//   err       sticky: clear pulse arrived mid-row
//   busy      any row capture in progress or any bank full
// -----------------------------------------------------------------------------
module m8x8_drain #(
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic [7:0]      clear_in,
   input  logic [8*DW-1:0] z_in,
   input  logic [7:0]      b_in,
   input  logic            m_ready,
   output logic            m_valid,
   output logic [8*DW-1:0] m_data,
   output logic [7:0]      m_bmask,
   output logic [2:0]      m_row,
   output logic            m_last,
   output logic            ovf,
   output logic            err,
   output logic            busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CAPT = 2'd1;
   localparam logic [1:0] ST_SKIP = 2'd2;

   logic [1:0]    state   [8];
   logic [1:0]    state_n [8];
   logic [2:0]    cnt     [8];
   logic [2:0]    cnt_n   [8];
   logic [7:0]    wsel;
   logic [7:0]    wsel_n;
   logic [7:0]    wr_en;
   logic [7:0]    written   [2];
   logic [7:0]    written_n [2];
   logic [7:0]    set_w     [2];
   logic [1:0]    full;
   logic [1:0]    full_set;
   logic [1:0]    freed;
   logic [1:0]    eff_full;
   logic          rsel;
   logic [2:0]    rrow;
   logic          ovf_set;
   logic          err_set;
   logic          tgt;
   logic [DW-1:0] mem_z [2][8][8];   // [bank][row][column]
   logic [7:0]    mem_b [2][8];      // [bank][row], bit = column

   // Row capture next-state, bank write-tracking and full detection.
   always_comb begin
      // A bank released by the reader this cycle is already available to a
      // row starting in the same cycle.
      freed = 2'b00;
      if (full[rsel] && m_ready && (rrow == 3'd7)) begin
         freed[rsel] = 1'b1;
      end else begin
         freed = 2'b00;
      end
      eff_full = full & ~freed;
      ovf_set  = 1'b0;
      err_set  = 1'b0;
      wr_en    = 8'h00;
      set_w[0] = 8'h00;
      set_w[1] = 8'h00;
      wsel_n   = wsel;
      tgt      = 1'b0;
      for (int r = 0; r < 8; r++) begin
         state_n[r] = state[r];
         cnt_n[r]   = cnt[r];
         if (enable) begin
            case (state[r])
               ST_IDLE: begin
                  if (clear_in[r]) begin
                     cnt_n[r] = 3'd0;
                     if (eff_full[wsel[r]]) begin
                        state_n[r] = ST_SKIP;
                        ovf_set    = 1'b1;
                     end else begin
                        state_n[r] = ST_CAPT;
                     end
                  end else begin
                     state_n[r] = ST_IDLE;
                  end
               end
               ST_CAPT, ST_SKIP: begin
                  cnt_n[r] = cnt[r] + 3'd1;
                  if (state[r] == ST_CAPT) begin
                     wr_en[r] = 1'b1;
                  end else begin
                     wr_en[r] = 1'b0;
                  end
                  if (cnt[r] == 3'd7) begin
                     // A skipped row never claimed its bank, so it keeps it.
                     if (state[r] == ST_CAPT) begin
                        set_w[wsel[r]][r] = 1'b1;
                        tgt               = ~wsel[r];
                     end else begin
                        tgt = wsel[r];
                     end
                     wsel_n[r] = tgt;
                     if (clear_in[r]) begin
                        cnt_n[r] = 3'd0;
                        if (eff_full[tgt]) begin
                           state_n[r] = ST_SKIP;
                           ovf_set    = 1'b1;
                        end else begin
                           state_n[r] = ST_CAPT;
                        end
                     end else begin
                        state_n[r] = ST_IDLE;
                     end
                  end else begin
                     if (clear_in[r]) begin
                        err_set = 1'b1;
                     end else begin
                        err_set = err_set;
                     end
                  end
               end
               default: begin
                  state_n[r] = ST_IDLE;
                  cnt_n[r]   = 3'd0;
               end
            endcase
         end else begin
            state_n[r] = state[r];
         end
      end
      // The last row slot written turns the bank full at the same edge, so
      // m_valid follows the final element write by one cycle.
      for (int b = 0; b < 2; b++) begin
         written_n[b] = written[b] | set_w[b];
         if (&written_n[b]) begin
            full_set[b]  = 1'b1;
            written_n[b] = 8'h00;
         end else begin
            full_set[b]  = 1'b0;
         end
      end
   end

   // Capture FSM state, bank flags and sticky error flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < 8; r++) begin
            state[r] <= ST_IDLE;
            cnt[r]   <= 3'd0;
         end
         wsel       <= 8'h00;
         written[0] <= 8'h00;
         written[1] <= 8'h00;
         full       <= 2'b00;
         ovf        <= 1'b0;
         err        <= 1'b0;
      end else begin
         for (int r = 0; r < 8; r++) begin
            state[r] <= state_n[r];
            cnt[r]   <= cnt_n[r];
         end
         wsel       <= wsel_n;
         written[0] <= written_n[0];
         written[1] <= written_n[1];
         full       <= (full & ~freed) | full_set;
         ovf        <= ovf | ovf_set;
         err        <= err | err_set;
      end
   end

   // Reader bank pointer and row counter; advances on every accepted beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsel <= 1'b0;
         rrow <= 3'd0;
      end else if (m_valid && m_ready) begin
         if (rrow == 3'd7) begin
            rsel <= ~rsel;
            rrow <= 3'd0;
         end else begin
            rrow <= rrow + 3'd1;
         end
      end else begin
         rrow <= rrow;
      end
   end

   // Bank storage; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      for (int r = 0; r < 8; r++) begin
         if (wr_en[r]) begin
            mem_z[wsel[r]][r][cnt[r]] <= z_in[r*DW +: DW];
            mem_b[wsel[r]][r][cnt[r]] <= b_in[r];
         end
      end
   end

   // Output view of the current reader row and status.
   always_comb begin
      m_valid = full[rsel];
      m_row   = rrow;
      m_last  = (rrow == 3'd7);
      m_bmask = mem_b[rsel][rrow];
      m_data  = '0;
      for (int c = 0; c < 8; c++) begin
         m_data[c*DW +: DW] = mem_z[rsel][rrow][c];
      end
      busy = (|full);
      for (int r = 0; r < 8; r++) begin
         if (state[r] != ST_IDLE) begin
            busy = 1'b1;
         end else begin
            busy = busy;
         end
      end
   end

endmodule

// File: tb/tb_m8x8_drain.sv
// -----------------------------------------------------------------------------
// Testbench for m8x8_drain. Tiles are generated as 8x8 element/bit arrays,
// the expected output is the ordered list of tile rows that must appear, and
// a negedge process compares every presented beat against the head of that
// list.
// -----------------------------------------------------------------------------
module tb_m8x8_drain;

   localparam int DW = 32;

   typedef struct {
      logic [8*DW-1:0] d;
      logic [7:0]      m;
      logic [2:0]      row;
      logic            last;
   } beat_t;

   logic            clk;
   logic            reset;
   logic            enable;
   logic [7:0]      clear_in;
   logic [8*DW-1:0] z_in;
   logic [7:0]      b_in;
   logic            m_ready;
   logic            m_valid;
   logic [8*DW-1:0] m_data;
   logic [7:0]      m_bmask;
   logic [2:0]      m_row;
   logic            m_last;
   logic            ovf;
   logic            err;
   logic            busy;

   beat_t         exp_q[$];
   beat_t         cmp_e;
   beat_t         pin;
   logic [DW-1:0] zt [4][8][8];
   logic          bt [4][8][8];
   int            skew [8];
   int            rmode;
   int            n_cmp;
   int            n_bad;

   m8x8_drain #(.DW(DW)) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .clear_in (clear_in),
      .z_in     (z_in),
      .b_in     (b_in),
      .m_ready  (m_ready),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .m_bmask  (m_bmask),
      .m_row    (m_row),
      .m_last   (m_last),
      .ovf      (ovf),
      .err      (err),
      .busy     (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [8*DW-1:0] act, input logic [8*DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      case (rmode)
         0:       m_ready = 1'b0;
         1:       m_ready = 1'b1;
         2:       m_ready = ~m_ready;
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      enable   = 1'b0;
      clear_in = 8'h00;
      exp_q.delete();
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Build nt tiles: pattern tiles use z = 1000*k + 100*r + c, b = c[0].
   task automatic gen(input int nt, input bit pat, input int smode);
      for (int k = 0; k < nt; k++)
         for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
               if (pat) begin
                  zt[k][r][c] = DW'(1000 * k + 100 * r + c);
                  bt[k][r][c] = 1'(c % 2);
               end else begin
                  zt[k][r][c] = $urandom();
                  bt[k][r][c] = 1'($urandom_range(0, 1));
               end
            end
      for (int r = 0; r < 8; r++)
         skew[r] = (smode == 0) ? r : int'($urandom_range(0, 3));
   endtask

   // Expected output: the first `keep` tiles, row by row, in order.
   task automatic push(input int keep);
      beat_t b;
      for (int k = 0; k < keep; k++)
         for (int r = 0; r < 8; r++) begin
            b.d = '0;
            for (int c = 0; c < 8; c++) begin
               b.d[c*DW +: DW] = zt[k][r][c];
               b.m[c]          = bt[k][r][c];
            end
            b.row  = 3'(r);
            b.last = (r == 7);
            exp_q.push_back(b);
         end
   endtask

   // Drive nt back-to-back tiles; row r of tile k clears on enabled step
   // 8*k + skew[r] and streams its elements on the following eight steps.
   task automatic drive(input int nt, input int gmode, input int err_step, input int abort_step);
      int maxs;
      int total;
      int st;
      maxs = 0;
      for (int r = 0; r < 8; r++)
         if (skew[r] > maxs) maxs = skew[r];
      total = (nt - 1) * 8 + maxs + 9;
      for (int s = 0; s < total; s++) begin
         int nd;
         nd = 0;
         if (gmode == 1 && s == 12) nd = 5;
         else if (gmode == 2 && $urandom_range(0, 3) == 0) nd = int'($urandom_range(1, 3));
         for (int g = 0; g < nd; g++) begin
            enable   = 1'b0;
            clear_in = 8'h00;
            z_in     = {8{$urandom()}};
            b_in     = 8'($urandom_range(0, 255));
            tick();
         end
         enable   = 1'b1;
         clear_in = 8'h00;
         z_in     = {8{$urandom()}};
         b_in     = 8'($urandom_range(0, 255));
         for (int r = 0; r < 8; r++)
            for (int k = 0; k < nt; k++) begin
               st = k * 8 + skew[r];
               if (s == st) clear_in[r] = 1'b1;
               if (s > st && s <= st + 8) begin
                  z_in[r*DW +: DW] = zt[k][r][s-st-1];
                  b_in[r]          = bt[k][r][s-st-1];
               end
            end
         if (s == err_step) clear_in[3] = 1'b1;
         tick();
         if (s == abort_step) begin
            #3;
            reset = 1'b1;
            #1;
            chk("async_reset_m_valid", 256'(m_valid), 256'd0);
            chk("async_reset_busy", 256'(busy), 256'd0);
            do_reset();
            return;
         end
      end
      clear_in = 8'h00;
   endtask

   task automatic drain();
      int i;
      i = 0;
      while (!(exp_q.size() == 0 && !m_valid) && i < 400) begin
         tick();
         i++;
      end
      n_cmp++;
      if (i >= 400) begin
         n_bad++;
         $display("FAIL drain_timeout: %0d beats still pending, expected 0", exp_q.size());
      end
   endtask

   // Every presented beat must equal the head of the expected list; it is
   // retired only when accepted, so stalled beats are re-checked each cycle.
   always @(negedge clk) begin
      if (!reset && m_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: m_valid=1 row %0d, expected no beat", m_row);
         end else begin
            cmp_e = exp_q[0];
            chk("m_data", m_data, cmp_e.d);
            chk("m_bmask", 256'(m_bmask), 256'(cmp_e.m));
            chk("m_row", 256'(m_row), 256'(cmp_e.row));
            chk("m_last", 256'(m_last), 256'(cmp_e.last));
            if (m_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      rmode    = 1;
      m_ready  = 1'b1;
      enable   = 1'b0;
      clear_in = 8'h00;
      z_in     = '0;
      b_in     = 8'h00;
      reset    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // reset state
      chk("rst_m_valid", 256'(m_valid), 256'd0);
      chk("rst_busy", 256'(busy), 256'd0);
      chk("rst_ovf", 256'(ovf), 256'd0);
      chk("rst_err", 256'(err), 256'd0);
      chk("rst_m_row", 256'(m_row), 256'd0);
      chk("rst_m_last", 256'(m_last), 256'd0);

      // basic drain with row skew r
      gen(1, 1'b1, 0);
      push(1);
      pin = exp_q[5];
      chk("model_r5c3", 256'(pin.d[3*DW +: DW]), 256'd503);
      chk("model_mask", 256'(pin.m), 256'hAA);
      pin = exp_q[7];
      chk("model_last7", 256'(pin.last), 256'd1);
      chk("model_r7c0", 256'(pin.d[0 +: DW]), 256'd700);
      drive(1, 0, -1, -1);
      chk("latency_m_valid", 256'(m_valid), 256'd1);
      chk("latency_m_row", 256'(m_row), 256'd0);
      drain();
      chk("basic_err", 256'(err), 256'd0);
      chk("basic_ovf", 256'(ovf), 256'd0);
      chk("idle_busy", 256'(busy), 256'd0);

      // back-to-back tiles
      gen(2, 1'b0, 1);
      push(2);
      drive(2, 0, -1, -1);
      drain();
      chk("b2b_err", 256'(err), 256'd0);
      chk("b2b_ovf", 256'(ovf), 256'd0);

      // overflow: three tiles with downstream stalled
      rmode   = 0;
      m_ready = 1'b0;
      gen(3, 1'b0, 1);
      push(2);
      drive(3, 0, -1, -1);
      chk("ovf_set", 256'(ovf), 256'd1);
      chk("ovf_m_valid", 256'(m_valid), 256'd1);
      chk("ovf_busy", 256'(busy), 256'd1);
      rmode = 1;
      drain();
      chk("ovf_sticky", 256'(ovf), 256'd1);
      do_reset();
      chk("ovf_cleared", 256'(ovf), 256'd0);

      // protocol error on row 3 at cnt=4, plus a 5-cycle enable gap
      gen(1, 1'b1, 0);
      push(1);
      drive(1, 1, 8, -1);
      drain();
      chk("err_set", 256'(err), 256'd1);
      chk("err_ovf", 256'(ovf), 256'd0);
      do_reset();
      chk("err_cleared", 256'(err), 256'd0);

      // backpressure: m_ready toggles every cycle
      rmode = 2;
      gen(1, 1'b1, 0);
      push(1);
      drive(1, 0, -1, -1);
      drain();
      rmode = 1;

      // asynchronous reset during row-5 capture, then a clean tile
      gen(1, 1'b0, 0);
      push(1);
      drive(1, 0, -1, 9);
      chk("post_reset_m_valid", 256'(m_valid), 256'd0);
      chk("post_reset_busy", 256'(busy), 256'd0);
      gen(1, 1'b1, 0);
      push(1);
      drive(1, 0, -1, -1);
      drain();

      // randomized pairs with random ready and enable gaps
      for (int it = 0; it < 4; it++) begin
         rmode = 3;
         gen(2, 1'b0, 1);
         push(2);
         drive(2, 2, -1, -1);
         drain();
         chk("rand_ovf", 256'(ovf), 256'd0);
         chk("rand_err", 256'(err), 256'd0);
      end
      rmode = 1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/m8x8_drain.md
M8X8_DRAIN -- requirements
Module: m8x8_drain

Interface
REQ-001 Parameter: DW, 32, element width in bits; the array is fixed at 8x8.
REQ-002 Ports, clock and reset first:
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, asynchronous active-high reset.
- enable, in, 1, capture-side advance; same meaning as the array global enable.
- clear_in, in, 8, per-row clear pulses emerging from the array; bit r is row r.
- z_in, in, 8*DW, per-row serial result stream; row r occupies bits [r*DW +: DW].
- b_in, in, 8, per-row relu-derivative bit accompanying z_in.
- m_ready, in, 1, downstream accepts the current row beat.
- m_valid, out, 1, a row beat is presented.
- m_data, out, 8*DW, one tile row; column c occupies bits [c*DW +: DW].
- m_bmask, out, 8, derivative bits of that row; bit c is column c.
- m_row, out, 3, row index of the beat.
- m_last, out, 1, high on row 7 of the tile.
- ovf, out, 1, sticky: a tile row was dropped.
- err, out, 1, sticky: protocol violation.
- busy, out, 1, any row capture in progress or any bank full.

Function
REQ-003 Two tile banks, each holding 8x8 DW-bit elements plus 8x8 derivative bits. Each bank has a full flag.
REQ-004 Each row r has an independent FSM with states IDLE, CAPT and SKIP, a 3-bit counter cnt[r] and a bank pointer wsel[r].
REQ-005 All capture FSMs hold state on cycles where enable=0. Cycles where enable=1 are "enabled cycles" below.
REQ-006 IDLE, enabled cycle, clear_in[r]=1, bank wsel[r] not full: go to CAPT with cnt=0. Element data begins on the next enabled cycle.
REQ-007 IDLE, enabled cycle, clear_in[r]=1, bank wsel[r] full: go to SKIP with cnt=0 and set ovf.
REQ-008 CAPT, each enabled cycle: write z_in[r] and b_in[r] to bank[wsel[r]] row r, column cnt, then increment cnt.
- When cnt=7, the row-r slot of that bank is marked written and wsel[r] toggles.
- If clear_in[r]=1 in that same cycle, the next tile starts immediately: apply REQ-006/REQ-007 against the new wsel[r]; otherwise go to IDLE.
REQ-009 SKIP counts 8 enabled cycles without writing and then behaves as CAPT at cnt=7. A clear_in[r] on that last cycle starts the next tile; wsel[r] does not toggle.
REQ-010 clear_in[r]=1 in CAPT or SKIP with cnt<7 sets err and is otherwise ignored.
REQ-011 A bank becomes full on the cycle after all 8 row slots are written. Its row-written bits then clear.
REQ-012 The reader holds a bank pointer rsel and a row counter rrow. m_valid = full[rsel].
- m_data, m_bmask and m_row = rrow reflect bank[rsel] row rrow; m_last = (rrow==7).
REQ-013 On m_valid && m_ready: rrow increments. At rrow=7, full[rsel] clears, rsel toggles and rrow wraps to 0.
REQ-014 m_data, m_bmask, m_row and m_last are stable while m_valid=1 and m_ready=0. Data is never overwritten while its bank is full.
REQ-015 The reader is not gated by enable.
REQ-016 Same-cycle free and start: if a bank is freed in the same cycle a row start targets it, the bank counts as not full and the capture proceeds.
REQ-017 Elements are stored bit-exact; no arithmetic is applied. Latency from the last element write of the last row to m_valid is 1 cycle.
REQ-018 ovf and err clear only on reset.

Reset
REQ-019 Asynchronous reset=1 immediately forces:
- all FSMs to IDLE; cnt, wsel, rsel and rrow to 0;
- full flags and row-written bits to 0;
- m_valid, m_row, m_last, ovf, err and busy to 0.
REQ-020 Bank contents are not reset; m_data and m_bmask are don't-care while m_valid=0.
REQ-021 Reset mid-capture or mid-drain discards the partial tile. No beat is emitted for it after reset deasserts.

Verification
REQ-022 Basic drain:
- Stimulus: rows 0..7 cleared with skew r cycles, z = 100*r + c, b = c[0]; m_ready=1.
- Response: 8 beats, m_row 0..7, m_data column c = 100*row + c, m_bmask = 8'hAA, m_last on beat 7 only.
REQ-023 Back-to-back tiles:
- Stimulus: second clear_in on each row's cnt=7 cycle; m_ready=1.
- Response: tile 2 lands in bank 1, both tiles drain in order, err=0.
REQ-024 Overflow:
- Stimulus: m_ready=0, three consecutive tiles.
- Response: banks 0 and 1 full, third tile dropped, ovf=1. After m_ready=1, only tiles 1 and 2 appear.
REQ-025 Protocol error and enable gating:
- clear_in[3] at cnt=4 sets err=1; the row-3 data is unaffected.
- enable=0 for 5 cycles mid-capture: the element sequence is preserved and the output matches REQ-022.
REQ-026 Backpressure:
- Stimulus: toggle m_ready every cycle during the drain.
- Response: m_data held while stalled; beats are neither lost nor duplicated.
REQ-027 Asynchronous reset:
- Stimulus: assert reset between clock edges during row-5 capture.
- Response: m_valid=0 and busy=0 before the next edge; a subsequent clean tile drains correctly.
